// File: rtl/baud_rate_gen_if.sv
// rtl/baud_rate_gen_if.sv - divisor input and tick strobes of the baud-rate generator
interface baud_rate_gen_if #(
  parameter int DVSR_BIT = 11
);
  logic [DVSR_BIT-1:0] divsr;
  logic                tick;
  logic                bit_tick;

  modport master (
    output divsr,
    input  tick,
    input  bit_tick
  );

  modport slave (
    input  divsr,
    output tick,
    output bit_tick
  );
endinterface

// File: rtl/baud_rate_gen.sv
// rtl/baud_rate_gen.sv - programmable oversample tick and per-bit tick generator
module baud_rate_gen #(
  parameter int DVSR_BIT   = 11,
  parameter int OVERSAMPLE = 16
) (
  input  logic           clk,
  input  logic           reset,
  baud_rate_gen_if.slave bus
);
  localparam int SUB_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [SUB_W-1:0]    SUB_LAST = SUB_W'(OVERSAMPLE - 1);
  localparam logic [DVSR_BIT-1:0] CNT_ONE  = DVSR_BIT'(1);
  localparam logic [SUB_W-1:0]    SUB_ONE  = SUB_W'(1);

  logic [DVSR_BIT-1:0] cnt;
  logic [DVSR_BIT-1:0] div_act;
  logic [SUB_W-1:0]    sub;
  logic                tick_q;
  logic                bit_tick_q;
  logic                wrap;

  // Equality-only compare: cnt never passes div_act, so the all-ones divisor cannot overflow.
  assign wrap = (cnt == div_act);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt        <= '0;
      div_act    <= bus.divsr;
      sub        <= '0;
      tick_q     <= 1'b0;
      bit_tick_q <= 1'b0;
    end else if (wrap) begin
      // The shadow divisor only reloads here, so a period in progress is never disturbed.
      cnt     <= '0;
      div_act <= bus.divsr;
      tick_q  <= 1'b1;
      if (sub == SUB_LAST) begin
        sub        <= '0;
        bit_tick_q <= 1'b1;
      end else begin
        sub        <= sub + SUB_ONE;
        bit_tick_q <= 1'b0;
      end
    end else begin
      cnt        <= cnt + CNT_ONE;
      tick_q     <= 1'b0;
      bit_tick_q <= 1'b0;
    end
  end

  assign bus.tick     = tick_q;
  assign bus.bit_tick = bit_tick_q;
endmodule

// File: tb/tb_baud_rate_gen.sv
// tb/tb_baud_rate_gen.sv - self-checking bench for baud_rate_gen
module tb_baud_rate_gen;
  localparam int DVSR_BIT = 11;
  localparam int OS       = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  baud_rate_gen_if #(.DVSR_BIT(DVSR_BIT)) bus ();

  baud_rate_gen #(
    .DVSR_BIT  (DVSR_BIT),
    .OVERSAMPLE(OS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: a schedule of wrap edges, each D+1 edges after the previous one.
  bit     m_valid = 1'b0;
  longint m_edge  = 0;
  longint m_next  = 0;
  longint m_wraps = 0;
  logic   m_tick  = 1'b0;
  logic   m_bit   = 1'b0;

  typedef struct {
    int dv;
    int first;
    int period;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
  endtask

  task automatic cyc();
    logic   r;
    longint dv;
    r  = reset;
    dv = longint'(bus.divsr);
    @(posedge clk);
    #1;
    if (r) begin
      m_valid = 1'b1;
      m_edge  = 0;
      m_next  = dv + 1;
      m_wraps = 0;
      m_tick  = 1'b0;
      m_bit   = 1'b0;
    end else begin
      m_edge++;
      if (m_edge == m_next) begin
        m_tick = 1'b1;
        m_wraps++;
        m_bit  = ((m_wraps % OS) == 0);
        m_next = m_edge + dv + 1;
      end else begin
        m_tick = 1'b0;
        m_bit  = 1'b0;
      end
    end
    if (m_valid)
      check($sformatf("model_e%0d", m_edge), longint'({bus.tick, bus.bit_tick}),
            longint'({m_tick, m_bit}));
  endtask

  task automatic do_reset(input int dv, input int n);
    reset     = 1'b1;
    bus.divsr = DVSR_BIT'(dv);
    repeat (n) cyc();
    check("reset_tick", longint'(bus.tick), 0);
    check("reset_bit_tick", longint'(bus.bit_tick), 0);
    reset = 1'b0;
  endtask

  // Cycles until the selected strobe (0 = tick, 1 = bit_tick) is high; -1 on timeout.
  task automatic wait_ev(input bit sel, input int limit, output int n);
    logic seen;
    n = 0;
    seen = 1'b0;
    while (!seen && n < limit) begin
      cyc();
      n++;
      seen = sel ? bus.bit_tick : bus.tick;
    end
    if (!seen) begin
      check($sformatf("wait_timeout_sel%0d", sel), longint'(seen), 1);
      n = -1;
    end
  endtask

  initial begin
    int n;
    int n2;

    vt[0] = '{dv: 650,  first: 651,  period: 651};
    vt[1] = '{dv: 0,    first: 1,    period: 1};
    vt[2] = '{dv: 1,    first: 2,    period: 2};
    vt[3] = '{dv: 9,    first: 10,   period: 10};
    vt[4] = '{dv: 3,    first: 4,    period: 4};
    vt[5] = '{dv: 2047, first: 2048, period: 2048};

    bus.divsr = '0;

    for (int i = 0; i < 6; i++) begin
      do_reset(vt[i].dv, 2);
      wait_ev(1'b0, 5000, n);
      check($sformatf("first_tick_dv%0d", vt[i].dv), n, vt[i].first);
      for (int k = 0; k < 3; k++) begin
        wait_ev(1'b0, 5000, n);
        check($sformatf("tick_period_dv%0d_%0d", vt[i].dv, k), n, vt[i].period);
      end
    end

    // Divisor changed mid-period: current period still ends at 10 clocks.
    do_reset(9, 2);
    repeat (5) cyc();
    bus.divsr = DVSR_BIT'(3);
    wait_ev(1'b0, 100, n);
    check("change_rest_of_period", n, 5);
    wait_ev(1'b0, 100, n);
    check("change_new_period_a", n, 4);
    wait_ev(1'b0, 100, n);
    check("change_new_period_b", n, 4);

    // bit_tick period at divsr 650.
    do_reset(650, 2);
    wait_ev(1'b1, 20000, n);
    check("first_bit_tick", n, 16 * 651);
    wait_ev(1'b1, 20000, n);
    check("bit_tick_period", n, 16 * 651);

    // Reset at cnt = 300 aborts the count and restarts sub.
    do_reset(650, 2);
    repeat (300) cyc();
    reset = 1'b1;
    cyc();
    check("midreset_tick_low", longint'(bus.tick), 0);
    check("midreset_bit_low", longint'(bus.bit_tick), 0);
    reset = 1'b0;
    wait_ev(1'b0, 2000, n);
    check("midreset_first_tick", n, 651);
    wait_ev(1'b1, 20000, n2);
    check("midreset_first_bit_tick", n + n2, 16 * 651);

    // Randomized divisor changes and resets against the model.
    do_reset(int'($urandom_range(0, 15)), 2);
    for (int c = 0; c < 6000; c++) begin
      if ($urandom_range(0, 19) == 0) bus.divsr = DVSR_BIT'($urandom_range(0, 15));
      reset = ($urandom_range(0, 699) == 0);
      cyc();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
